// File: rtl/seg7_digit_scanner.sv
// Time-multiplexed scanner feeding one nibble at a time to a seven-segment decoder.
// New values are deferred to the frame boundary, so every frame shows one consistent value.
module seg7_digit_scanner #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 4,
   parameter int LZ_BLANK_DEF = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [4*DIGITS-1:0] value_in,
   input  logic                blank_en,
   output logic [3:0]          digit_out,
   output logic [DIGITS-1:0]   digit_sel,
   output logic                blank,
   output logic                scan_tick,
   output logic                frame_done,
   output logic                update_pending
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int VW = 4 * DIGITS;

   logic [CW-1:0]     count_q, count_d;
   logic [IW-1:0]     index_q, index_d;
   logic [VW-1:0]     shadow_q, shadow_d;
   logic [VW-1:0]     pending_q, pending_d;
   logic              pend_valid_q, pend_valid_d;
   logic              blank_en_q, blank_en_d;
   logic              last_digit;
   logic [DIGITS-1:0] upper_zero;
   logic              zero_acc;
   logic              unused_lz_def;

   // Integration-only tie-off default; the block itself ignores it.
   assign unused_lz_def = (LZ_BLANK_DEF != 0);

   assign scan_tick  = (count_q == CW'(PRESCALE - 1));
   assign last_digit = (index_q == IW'(DIGITS - 1));
   assign frame_done = scan_tick & last_digit;

   always_comb begin
      count_d      = scan_tick ? '0 : count_q + 1'b1;
      index_d      = index_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      pend_valid_d = pend_valid_q;
      blank_en_d   = blank_en;
      if (scan_tick) begin
         index_d = last_digit ? '0 : index_q + 1'b1;
      end
      if (frame_done) begin
         // A load landing exactly on the boundary beats an older pending value.
         if (load) begin
            shadow_d = value_in;
         end else if (pend_valid_q) begin
            shadow_d = pending_q;
         end
         pend_valid_d = 1'b0;
      end else if (load) begin
         pending_d    = value_in;
         pend_valid_d = 1'b1;
      end
   end

   // rst_n is expected to be released synchronously to clk by the reset tree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q      <= '0;
         index_q      <= '0;
         shadow_q     <= '0;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         blank_en_q   <= 1'b0;
      end else begin
         count_q      <= count_d;
         index_q      <= index_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         blank_en_q   <= blank_en_d;
      end
   end

   // upper_zero[i]: nibbles i..DIGITS-1 of the shadow are all zero.
   always_comb begin
      upper_zero = '0;
      zero_acc   = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_acc      = zero_acc & (shadow_q[4*i +: 4] == 4'h0);
         upper_zero[i] = zero_acc;
      end
   end

   assign digit_sel      = DIGITS'(1) << index_q;
   assign digit_out      = shadow_q[4*index_q +: 4];
   assign blank          = blank_en_q & (index_q != '0) & upper_zero[index_q];
   assign update_pending = pend_valid_q;

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// Bench for seg7_digit_scanner: two instances (PRESCALE 4 and 1) share stimulus and are
// checked every cycle against a cycle-count based model, plus literal scenario checks.
module tb_seg7_digit_scanner;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic        blank_en = 1'b0;
   logic [15:0] value_in = '0;

   logic [3:0] digit_out_a, digit_out_b;
   logic [3:0] digit_sel_a, digit_sel_b;
   logic       blank_a, blank_b, scan_tick_a, scan_tick_b;
   logic       frame_done_a, frame_done_b, update_pending_a, update_pending_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seg7_digit_scanner #(.DIGITS(4), .PRESCALE(4), .LZ_BLANK_DEF(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .blank_en(blank_en),
      .digit_out(digit_out_a), .digit_sel(digit_sel_a), .blank(blank_a),
      .scan_tick(scan_tick_a), .frame_done(frame_done_a), .update_pending(update_pending_a)
   );

   seg7_digit_scanner #(.DIGITS(4), .PRESCALE(1), .LZ_BLANK_DEF(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .blank_en(blank_en),
      .digit_out(digit_out_b), .digit_sel(digit_sel_b), .blank(blank_b),
      .scan_tick(scan_tick_b), .frame_done(frame_done_b), .update_pending(update_pending_b)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting at %0t", name, $time);
   endtask

   // Model: position in the frame is just cycles since reset modulo the frame length.
   int          m_cyc    [2];
   logic [15:0] m_shadow [2];
   logic [15:0] m_pend   [2];
   bit          m_pv     [2];
   bit          m_ben    [2];

   function automatic int ps(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int m_idx(input int k);
      return (m_cyc[k] / ps(k)) % D;
   endfunction

   function automatic bit m_tick(input int k);
      return (m_cyc[k] % ps(k)) == ps(k) - 1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_cyc[k] = 0; m_shadow[k] = '0; m_pend[k] = '0; m_pv[k] = 0; m_ben[k] = 0;
         end else begin
            if (m_tick(k) && m_idx(k) == D - 1) begin
               if (load) m_shadow[k] = value_in;
               else if (m_pv[k]) m_shadow[k] = m_pend[k];
               m_pv[k] = 0;
            end else if (load) begin
               m_pend[k] = value_in;
               m_pv[k]   = 1;
            end
            m_ben[k] = blank_en;
            m_cyc[k] = (m_cyc[k] + 1) % (D * ps(k));
         end
      end
   end

   task automatic cmp(input int k, input logic [3:0] sel, input logic [3:0] out,
                      input logic bl, input logic tk, input logic fd, input logic up);
      int          idx;
      string       p;
      logic [15:0] rest;
      idx  = m_idx(k);
      p    = (k == 0) ? "A " : "B ";
      rest = m_shadow[k] >> (4 * idx);
      check({p, "digit_sel"}, sel, 1 << idx);
      check({p, "digit_out"}, out, rest & 16'hF);
      check({p, "blank"}, bl, (m_ben[k] && idx != 0 && rest == 0) ? 1 : 0);
      check({p, "scan_tick"}, tk, m_tick(k) ? 1 : 0);
      check({p, "frame_done"}, fd, (m_tick(k) && idx == D - 1) ? 1 : 0);
      check({p, "update_pending"}, up, m_pv[k] ? 1 : 0);
   endtask

   always @(negedge clk) begin
      cmp(0, digit_sel_a, digit_out_a, blank_a, scan_tick_a, frame_done_a, update_pending_a);
      cmp(1, digit_sel_b, digit_out_b, blank_b, scan_tick_b, frame_done_b, update_pending_b);
   end

   logic [3:0] got_out  [4];
   logic [3:0] got_sel  [4];
   logic       got_blank[4];
   logic       got_pend;
   int         n_tick, n_fd;

   task automatic wait_boundary();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         load = 1'b0;
         n++;
      end while (!frame_done_a && n < 100);
      if (!frame_done_a) timeout("wait_boundary");
   endtask

   task automatic wait_sel(input logic [3:0] target);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         load = 1'b0;
         n++;
      end while (digit_sel_a != target && n < 100);
      if (digit_sel_a != target) timeout("wait_sel");
   endtask

   // Called at the negedge just before a boundary edge; samples one full frame of A.
   task automatic collect_frame();
      n_tick = 0;
      n_fd   = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         load = 1'b0;
         if (i % 4 == 0) begin
            got_out[i/4]   = digit_out_a;
            got_sel[i/4]   = digit_sel_a;
            got_blank[i/4] = blank_a;
         end
         if (i == 0) got_pend = update_pending_a;
         n_tick += int'(scan_tick_a);
         n_fd   += int'(frame_done_a);
      end
   endtask

   task automatic show(input logic [15:0] v, input logic ben);
      blank_en = ben;
      load     = 1'b1;
      value_in = v;
      wait_boundary();
      collect_frame();
   endtask

   task automatic expect_out(input string name, input logic [15:0] digits);
      logic [15:0] d;
      d = digits;
      for (int j = 0; j < 4; j++) check({name, " out"}, got_out[j], d[4*j +: 4]);
   endtask

   task automatic expect_blank(input string name, input logic [3:0] bl);
      logic [3:0] b;
      b = bl;
      for (int j = 0; j < 4; j++) check({name, " blank"}, got_blank[j], b[j]);
   endtask

   logic [15:0] masks [4];

   initial begin
      masks = '{16'hFFFF, 16'h00FF, 16'h000F, 16'h0F0F};
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset digit_sel", digit_sel_a, 4'b0001);
      check("reset digit_out", digit_out_a, 0);
      check("reset blank", blank_a, 0);
      check("reset update_pending", update_pending_a, 0);
      check("reset scan_tick", scan_tick_a, 0);
      check("reset scan_tick P1", scan_tick_b, 1);

      // Scan order
      rst_n    = 1'b1;
      load     = 1'b1;
      value_in = 16'h1234;
      wait_boundary();
      collect_frame();
      expect_out("scan", 16'h1234);
      for (int j = 0; j < 4; j++) check("scan sel", got_sel[j], 1 << j);
      check("scan ticks per frame", n_tick, 4);
      check("scan frame_done per frame", n_fd, 1);

      // Leading-zero blanking
      show(16'h0045, 1'b1);
      expect_out("lz45", 16'h0045);
      expect_blank("lz45", 4'b1100);
      show(16'h0045, 1'b0);
      expect_blank("lz45 off", 4'b0000);
      show(16'h0000, 1'b1);
      expect_out("lz0", 16'h0000);
      expect_blank("lz0", 4'b1110);
      show(16'h0A00, 1'b1);
      expect_out("lzA", 16'h0A00);
      expect_blank("lzA", 4'b1000);

      // Deferred load
      show(16'h1234, 1'b0);
      wait_sel(4'b0010);
      load     = 1'b1;
      value_in = 16'h5678;
      @(negedge clk);
      load = 1'b0;
      check("defer pending", update_pending_a, 1);
      wait_sel(4'b0100);
      check("defer old digit2", digit_out_a, 2);
      wait_sel(4'b1000);
      check("defer old digit3", digit_out_a, 1);
      wait_boundary();
      collect_frame();
      expect_out("defer new", 16'h5678);
      check("defer pending cleared", got_pend, 0);

      // Latest load wins
      wait_sel(4'b0001);
      load     = 1'b1;
      value_in = 16'h1111;
      wait_sel(4'b0100);
      load     = 1'b1;
      value_in = 16'h2222;
      wait_boundary();
      collect_frame();
      expect_out("latest", 16'h2222);

      // Load exactly on the boundary
      wait_sel(4'b0010);
      load     = 1'b1;
      value_in = 16'h1111;
      wait_boundary();
      check("bnd pending before", update_pending_a, 1);
      load     = 1'b1;
      value_in = 16'h9999;
      collect_frame();
      expect_out("bnd", 16'h9999);
      check("bnd pending cleared", got_pend, 0);

      // PRESCALE=1: advances every cycle; reset drops a pending value
      begin
         int n;
         n = 0;
         do begin @(negedge clk); n++; end while (digit_sel_b != 4'b0001 && n < 20);
      end
      @(negedge clk);
      check("P1 sel step", digit_sel_b, 4'b0010);
      check("P1 tick", scan_tick_b, 1);
      @(negedge clk);
      check("P1 sel step2", digit_sel_b, 4'b0100);
      @(negedge clk);
      @(negedge clk);
      check("P1 sel wrap", digit_sel_b, 4'b0001);
      load     = 1'b1;
      value_in = 16'hBEEF;
      @(negedge clk);
      load = 1'b0;
      check("P1 pending", update_pending_b, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async sel B", digit_sel_b, 4'b0001);
      check("async out B", digit_out_b, 0);
      check("async pending B", update_pending_b, 0);
      check("async tick B", scan_tick_b, 1);
      check("async sel A", digit_sel_a, 4'b0001);
      check("async out A", digit_out_a, 0);
      check("async pending A", update_pending_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart sel B", digit_sel_b, 4'b0010);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         check("dropped pending out B", digit_out_b, 0);
      end

      // Randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         load     = ($urandom_range(0, 7) == 0);
         value_in = 16'($urandom) & masks[$urandom_range(0, 3)];
         if ($urandom_range(0, 31) == 0) blank_en = ~blank_en;
         if ($urandom_range(0, 399) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      @(negedge clk);
      load = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
